mem_port_arbiter: RTL and testbench

Shares one single-port, synchronous-read memory between the CPU's instruction-fetch requester and its load/store requester. It sits between the PC/fetch path and the data path on one side and the unified memory on the other. Each cycle it grants at most one access and routes read responses back to the requester that issued them. A starvation counter bounds how long fetch can be locked out by back-to-back data traffic.

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous-read memory between
// the instruction-fetch requester and the load/store requester. Data has
// priority; a starvation counter forces a fetch grant after STARVE_LIMIT
// consecutive data grants that left fetch waiting. Read responses are routed
// back to whichever requester issued the read one cycle earlier.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_D    = 2'd2
  } src_t;

  src_t             rsp_src;
  src_t             rsp_src_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             starved;

  assign starved = (starve_cnt == LIMIT);

  // Grant decision and memory port drive; everything is held quiet in reset.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    if (!rst) begin
      if_gnt = if_req & (~d_req | starved);
      d_gnt  = d_req & ~if_gnt;
      mem_en = if_gnt | d_gnt;
      if (if_gnt) begin
        mem_addr = if_addr;
      end else if (d_gnt) begin
        mem_addr = d_addr;
        mem_we   = d_we;
        if (d_we) begin
          mem_wdata = d_wdata;
        end
      end
      stall = (if_req & ~if_gnt) | (d_req & ~d_gnt);
    end
  end

  // Next-state for response source and starvation counter.
  always_comb begin
    rsp_src_next    = SRC_NONE;
    starve_cnt_next = starve_cnt;
    if (if_gnt) begin
      rsp_src_next = SRC_IF;
    end else if (d_gnt && !d_we) begin
      rsp_src_next = SRC_D;
    end
    if (if_gnt || !if_req) begin
      starve_cnt_next = '0;
    end else if (d_gnt && !starved) begin
      starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  // Control state register; reset discards any in-flight read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_src    <= SRC_NONE;
      starve_cnt <= '0;
    end else begin
      rsp_src    <= rsp_src_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // A response pending across a reset assertion is suppressed while rst is high.
  assign if_rvalid = (rsp_src == SRC_IF) & ~rst;
  assign d_rvalid  = (rsp_src == SRC_D) & ~rst;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  logic [DATA_W-1:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall(stall)
  );

  // Single-port memory: write on the grant edge, read data one cycle later.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  // Preload one word through the arbiter's store path.
  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
    #1;
    chk("store_gnt", d_gnt, 1);
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = '0;
    #1;
    // reset: requests ignored, all outputs quiet
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stall", stall, 0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_if_rvalid", if_rvalid, 0);
    chk("post_rst_d_rvalid", d_rvalid, 0);
    chk("idle_mem_addr", mem_addr, 0);

    store(32'h10, 32'h00500093);
    store(32'h20, 32'hAAAA5555);
    store(32'h200, 32'h11112222);
    store(32'h300, 32'h33334444);
    #1;
    chk("store_no_rvalid", if_rvalid | d_rvalid, 0);

    // fetch only
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk("f_if_gnt", if_gnt, 1);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_we", mem_we, 0);
    chk("f_stall", stall, 0);
    tick();
    idle();
    #1;
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'h00500093);
    chk("f_d_rvalid", d_rvalid, 0);
    tick();

    // conflict: data wins while counter is 0
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    #1;
    chk("c_d_gnt", d_gnt, 1);
    chk("c_if_gnt", if_gnt, 0);
    chk("c_stall", stall, 1);
    chk("c_mem_addr", mem_addr, 32'h200);
    tick();
    d_req = 1'b0;
    #1;
    chk("c_d_rvalid", d_rvalid, 1);
    chk("c_d_rdata", d_rdata, 32'h11112222);
    chk("c_if_rvalid", if_rvalid, 0);
    chk("c_if_gnt2", if_gnt, 1);
    chk("c_mem_addr2", mem_addr, 32'h20);
    tick();
    idle();
    #1;
    chk("c_if_rvalid2", if_rvalid, 1);
    chk("c_if_rdata", if_rdata, 32'hAAAA5555);
    chk("c_d_rvalid2", d_rvalid, 0);
    tick();

    // starvation: 4 data grants, then forced fetch, then data again
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("s%0d_if_gnt", i), if_gnt, (i == 4));
      chk($sformatf("s%0d_d_gnt", i), d_gnt, (i != 4));
      chk($sformatf("s%0d_d_rvalid", i), d_rvalid, (i >= 1 && i <= 4));
      chk($sformatf("s%0d_if_rvalid", i), if_rvalid, (i == 5));
      tick();
    end
    idle();
    #1;
    chk("s_end_d_rvalid", d_rvalid, 1);
    chk("s_end_d_rdata", d_rdata, 32'h11112222);
    tick();

    // store followed by load from the same address
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    #1;
    chk("w_d_gnt", d_gnt, 1);
    chk("w_mem_we", mem_we, 1);
    chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w_mem_addr", mem_addr, 32'h40);
    tick();
    idle();
    #1;
    chk("w_if_rvalid", if_rvalid, 0);
    chk("w_d_rvalid", d_rvalid, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    #1;
    chk("w_load_mem_we", mem_we, 0);
    tick();
    idle();
    #1;
    chk("w_load_rvalid", d_rvalid, 1);
    chk("w_load_rdata", d_rdata, 32'hDEADBEEF);
    tick();

    // back-to-back: load then fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    #1;
    chk("b_d_gnt", d_gnt, 1);
    tick();
    idle();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk("b_if_gnt", if_gnt, 1);
    chk("b_d_rvalid", d_rvalid, 1);
    chk("b_d_rdata", d_rdata, 32'h33334444);
    chk("b_if_rvalid", if_rvalid, 0);
    tick();
    idle();
    #1;
    chk("b_if_rvalid2", if_rvalid, 1);
    chk("b_if_rdata", if_rdata, 32'h00500093);
    chk("b_d_rvalid2", d_rvalid, 0);
    tick();

    // reset while a fetch read is in flight
    if_req = 1'b1; if_addr = 32'h20;
    #1;
    chk("r_if_gnt", if_gnt, 1);
    tick();
    rst = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h0BAD0BAD;
    #1;
    chk("r_if_rvalid", if_rvalid, 0);
    chk("r_if_gnt_rst", if_gnt, 0);
    chk("r_d_gnt_rst", d_gnt, 0);
    chk("r_mem_en", mem_en, 0);
    chk("r_mem_we", mem_we, 0);
    chk("r_stall", stall, 0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("r_post_if_rvalid", if_rvalid, 0);
    chk("r_post_d_rvalid", d_rvalid, 0);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk("r_f_if_gnt", if_gnt, 1);
    chk("r_f_mem_addr", mem_addr, 32'h10);
    tick();
    idle();
    #1;
    chk("r_f_if_rvalid", if_rvalid, 1);
    chk("r_f_if_rdata", if_rdata, 32'h00500093);
    tick();

    // memory at 0x20 must be untouched by the store attempted during reset
    if_req = 1'b1; if_addr = 32'h20;
    tick();
    idle();
    #1;
    chk("r_mem_intact", if_rdata, 32'hAAAA5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
